// File: rtl/and_gate_pkg.sv
// Shared constants and helpers for the and_gate_unit slice.
// all_ones builds a right-aligned mask of ones for widths up to 64.
package and_gate_pkg;

    localparam int AND_WIDTH_DEF = 1;
    localparam int AND_CNT_W_DEF = 8;

    function automatic logic [63:0] all_ones(input int width);
        logic [63:0] w_mask;
        w_mask = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < width) begin
                w_mask[i] = 1'b1;
            end
        end
        return w_mask;
    endfunction

endpackage

// File: rtl/and_gate_sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over increment.
// Asynchronous active-high reset.
module and_gate_sat_counter
    import and_gate_pkg::*;
#(
    parameter int CNT_W = AND_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != CNT_MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/and_gate_unit.sv
// Bitwise AND with a combinational result and a registered, valid-qualified
// result that also drives a reduction-AND flag and an all-ones event counter.
module and_gate_unit
    import and_gate_pkg::*;
#(
    parameter int WIDTH = AND_WIDTH_DEF,
    parameter int CNT_W = AND_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    input  logic             cnt_clr,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic             out_valid,
    output logic             y_all,
    output logic [CNT_W-1:0] all_cnt
);

    localparam logic [WIDTH-1:0] ONES_MASK = WIDTH'(all_ones(WIDTH));

    logic [WIDTH-1:0] w_and;
    logic             w_cnt_inc;
    logic [WIDTH-1:0] r_y_q;
    logic             r_out_valid;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_and_bit
            assign w_and[gi] = a[gi] & b[gi];
        end
    endgenerate

    assign y = w_and;

    // y_q only moves on accepted inputs; out_valid marks the fresh capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y_q       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_y_q <= w_and;
            end
        end
    end

    assign y_q       = r_y_q;
    assign out_valid = r_out_valid;
    assign y_all     = &r_y_q;

    assign w_cnt_inc = in_valid && (w_and == ONES_MASK);

    and_gate_sat_counter #(
        .CNT_W(CNT_W)
    ) u_sat_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .inc  (w_cnt_inc),
        .count(all_cnt)
    );

endmodule

// File: tb/tb_and_gate_unit.sv
// Self-checking bench for and_gate_unit: WIDTH=1 truth table, WIDTH=4 registered
// path with a scoreboard, async reset, and CNT_W=2 saturation.
module tb_and_gate_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // WIDTH=1 instance
    logic rst;
    logic a1, b1, v1, clr1;
    logic y1, yq1, ov1, yall1;
    logic [7:0] cnt1;

    // WIDTH=4, CNT_W=8 instance
    logic [3:0] a4, b4, y4, yq4;
    logic v4, clr4, ov4, yall4;
    logic [7:0] cnt4;

    // WIDTH=4, CNT_W=2 instance
    logic rsts;
    logic [3:0] as_, bs, ys, yqs;
    logic vs, clrs, ovs, yalls;
    logic [1:0] cnts;

    and_gate_unit #(.WIDTH(1), .CNT_W(8)) u1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .in_valid(v1), .cnt_clr(clr1),
        .y(y1), .y_q(yq1), .out_valid(ov1), .y_all(yall1), .all_cnt(cnt1)
    );

    and_gate_unit #(.WIDTH(4), .CNT_W(8)) u4 (
        .clk(clk), .rst(rst), .a(a4), .b(b4), .in_valid(v4), .cnt_clr(clr4),
        .y(y4), .y_q(yq4), .out_valid(ov4), .y_all(yall4), .all_cnt(cnt4)
    );

    and_gate_unit #(.WIDTH(4), .CNT_W(2)) us (
        .clk(clk), .rst(rsts), .a(as_), .b(bs), .in_valid(vs), .cnt_clr(clrs),
        .y(ys), .y_q(yqs), .out_valid(ovs), .y_all(yalls), .all_cnt(cnts)
    );

    typedef struct {
        logic [3:0] yq;
        logic       yall;
    } exp_t;
    exp_t sb_q[$];
    logic [3:0] hold4;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       v;
        logic       c;
        logic [3:0] ey;
        logic [7:0] ecnt;
    } row_t;
    row_t rows[10];

    // One clocked transaction on u4: comb check, push, edge, pop/compare.
    task automatic step4(input logic [3:0] a, input logic [3:0] b, input logic v,
                         input logic c, input logic [3:0] ey, input logic [7:0] ecnt,
                         input string tag);
        exp_t e;
        @(negedge clk);
        a4 = a; b4 = b; v4 = v; clr4 = c;
        #1 chk({tag, " y"}, 32'(y4), 32'(ey));
        if (v) sb_q.push_back('{ey, &ey});
        @(posedge clk);
        #1;
        chk({tag, " out_valid"}, 32'(ov4), 32'(v));
        if (ov4) begin
            if (sb_q.size() == 0) begin
                chk({tag, " scoreboard depth"}, 32'(sb_q.size()), 32'd1);
            end else begin
                e = sb_q.pop_front();
                chk({tag, " y_q"}, 32'(yq4), 32'(e.yq));
                chk({tag, " y_all"}, 32'(yall4), 32'(e.yall));
                hold4 = e.yq;
            end
        end else begin
            chk({tag, " y_q hold"}, 32'(yq4), 32'(hold4));
        end
        chk({tag, " all_cnt"}, 32'(cnt4), 32'(ecnt));
        $display("txn %s a=%h b=%h v=%0d clr=%0d y_q=%h ov=%0d y_all=%0d cnt=%0d",
                 tag, a, b, v, c, yq4, ov4, yall4, cnt4);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_sat[5];
        logic [1:0] tt_a[4];
        logic [1:0] tt_b[4];
        logic       tt_y[4];

        rows[0] = '{4'hF, 4'hA, 1'b1, 1'b0, 4'hA, 8'd0};
        rows[1] = '{4'h3, 4'h5, 1'b0, 1'b0, 4'h1, 8'd0};
        rows[2] = '{4'hF, 4'hF, 1'b1, 1'b0, 4'hF, 8'd1};
        rows[3] = '{4'hF, 4'hF, 1'b1, 1'b0, 4'hF, 8'd2};
        rows[4] = '{4'hF, 4'hF, 1'b1, 1'b0, 4'hF, 8'd3};
        rows[5] = '{4'hF, 4'hF, 1'b1, 1'b1, 4'hF, 8'd0};
        rows[6] = '{4'hF, 4'hF, 1'b0, 1'b0, 4'hF, 8'd0};
        rows[7] = '{4'hC, 4'h6, 1'b1, 1'b0, 4'h4, 8'd0};
        rows[8] = '{4'hF, 4'hF, 1'b1, 1'b0, 4'hF, 8'd1};
        rows[9] = '{4'h0, 4'hF, 1'b0, 1'b1, 4'h0, 8'd0};
        exp_sat = '{1, 2, 3, 3, 3};

        rst = 1'b1; rsts = 1'b1;
        a1 = 0; b1 = 0; v1 = 0; clr1 = 0;
        a4 = 4'hF; b4 = 4'h5; v4 = 0; clr4 = 0;
        as_ = 0; bs = 0; vs = 0; clrs = 0;
        hold4 = 4'h0;

        #1;
        chk("reset y_q", 32'(yq4), 32'd0);
        chk("reset out_valid", 32'(ov4), 32'd0);
        chk("reset y_all", 32'(yall4), 32'd0);
        chk("reset all_cnt", 32'(cnt4), 32'd0);
        chk("reset y comb", 32'(y4), 32'h5);
        $display("txn reset y_q=%h ov=%0d y_all=%0d cnt=%0d y=%h", yq4, ov4, yall4, cnt4, y4);

        @(negedge clk);
        rst = 1'b0; rsts = 1'b0;
        a4 = 4'h0; b4 = 4'h0;

        for (int i = 0; i < 10; i++) begin
            step4(rows[i].a, rows[i].b, rows[i].v, rows[i].c, rows[i].ey, rows[i].ecnt,
                  $sformatf("row%0d", i));
        end

        // Build y_q=A, all_cnt=2, then hit reset between edges with a valid in flight.
        step4(4'hF, 4'hF, 1'b1, 1'b0, 4'hF, 8'd1, "pre_rst0");
        step4(4'hF, 4'hF, 1'b1, 1'b0, 4'hF, 8'd2, "pre_rst1");
        step4(4'hA, 4'hF, 1'b1, 1'b0, 4'hA, 8'd2, "pre_rst2");
        @(negedge clk);
        a4 = 4'hF; b4 = 4'hF; v4 = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("async y_q", 32'(yq4), 32'd0);
        chk("async out_valid", 32'(ov4), 32'd0);
        chk("async y_all", 32'(yall4), 32'd0);
        chk("async all_cnt", 32'(cnt4), 32'd0);
        a4 = 4'h6; b4 = 4'h3;
        #1 chk("async y comb", 32'(y4), 32'h2);
        $display("txn async_rst y_q=%h ov=%0d y_all=%0d cnt=%0d y=%h", yq4, ov4, yall4, cnt4, y4);
        sb_q.delete();
        hold4 = 4'h0;
        @(posedge clk);
        #1 chk("in-reset edge y_q", 32'(yq4), 32'd0);

        @(negedge clk);
        rst = 1'b0; a4 = 4'h3; b4 = 4'h7; v4 = 1'b1;
        @(posedge clk);
        #1;
        chk("first capture y_q", 32'(yq4), 32'h3);
        chk("first capture out_valid", 32'(ov4), 32'd1);
        $display("txn release y_q=%h ov=%0d", yq4, ov4);
        @(negedge clk);
        v4 = 1'b0;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            as_ = 4'hF; bs = 4'hF; vs = 1'b1; clrs = 1'b0;
            @(posedge clk);
            #1 chk($sformatf("sat cnt%0d", i), 32'(cnts), 32'(exp_sat[i]));
            $display("txn sat%0d cnt=%0d", i, cnts);
        end
        @(negedge clk);
        vs = 1'b0;

        tt_a = '{2'd0, 2'd0, 2'd1, 2'd1};
        tt_b = '{2'd0, 2'd1, 2'd0, 2'd1};
        tt_y = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            a1 = tt_a[i][0]; b1 = tt_b[i][0];
            #10 chk($sformatf("truth %0d%0d", tt_a[i][0], tt_b[i][0]), 32'(y1), 32'(tt_y[i]));
            $display("txn truth a=%0d b=%0d y=%0d", a1, b1, y1);
        end

        a1 = 1'b0; b1 = 1'bx;
        #1 chk("x a0", 32'(y1), 32'd0);
        a1 = 1'b1;
        #1 chk("x a1", 32'(y1), 32'(b1));
        $display("txn xprop a=%b b=%b y=%b", a1, b1, y1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
